// File: rtl/zx_vram_pkg.sv
// Shared types and constants for the ZX Spectrum video RAM arbiter.
// The screen is a 6144-byte bitmap followed by 768 attribute bytes.
package zx_vram_pkg;

  localparam int VRAM_AW        = 13;
  localparam int VRAM_DW        = 8;
  localparam int VRAM_ATTR_BASE = 6144;
  localparam int VRAM_SIZE      = 6912;

  // Which requester a RAM access belongs to.
  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  // One slot of the return-path tag pipe.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_VID};

endpackage

// File: rtl/vram_tag_pipe.sv
// Latency-matched tag shift register: RAM_LAT+1 stages of {valid, owner}.
// Stage 0 is loaded on the issue edge, so the last stage lines up with the
// cycle in which the RAM read data is valid.
module vram_tag_pipe
  import zx_vram_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_valid,
  input  logic i_owner,
  output logic o_valid,
  output logic o_owner
);

  tag_t r_pipe [RAM_LAT+1];

  // Shift tags one stage per clock; synchronous clear drops reads in flight.
  // NOTE: only this small valid/owner pipe is reset -- the valid bits decide
  // whether an rvalid ever fires, so stale tags must not survive reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i <= RAM_LAT; i++) r_pipe[i] <= TAG_IDLE;
    end else begin
      r_pipe[0] <= '{valid: i_valid, owner: owner_e'(i_owner)};
      for (int i = 1; i <= RAM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_valid = r_pipe[RAM_LAT].valid;
  assign o_owner = r_pipe[RAM_LAT].owner;

endmodule

// File: rtl/zx_vram_arbiter.sv
// ZX Spectrum video RAM arbiter: one RAM access per clock shared between the
// video fetch pipeline (priority) and the CPU bus. Grants are combinational,
// the RAM interface is registered, read data is routed back via a tag pipe.
// Optional starvation guard for the CPU: define ZX_VRAM_STARVE_GUARD_EN.
module zx_vram_arbiter
  import zx_vram_pkg::*;
#(
  parameter int AW           = VRAM_AW,
  parameter int DW           = VRAM_DW,
  parameter int RAM_LAT      = 1,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic          w_vid_gnt;
  logic          w_cpu_gnt;
  logic          w_force_cpu;
  logic          w_ret_valid;
  logic          w_ret_owner;

  logic          r_ram_ce;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;
  logic          r_vid_rvalid;
  logic [DW-1:0] r_vid_rdata;
  logic          r_cpu_rvalid;
  logic [DW-1:0] r_cpu_rdata;

`ifdef ZX_VRAM_STARVE_GUARD_EN
  localparam int CW = $clog2(CPU_MAX_WAIT + 1);

  logic [CW-1:0] r_wait_cnt;

  assign w_force_cpu = (r_wait_cnt == CW'(CPU_MAX_WAIT));

  // Count consecutive denied CPU cycles; a grant or a dropped request clears it.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wait_cnt <= '0;
    end else if (!cpu_req || w_cpu_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != CW'(CPU_MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end
`else
  assign w_force_cpu = 1'b0;
`endif

  // Video has priority; the CPU wins contention only when the guard fires.
  // NOTE: both grants get a default first so no path leaves them unassigned
  // (that would infer a latch).
  always_comb begin
    w_vid_gnt = 1'b0;
    w_cpu_gnt = 1'b0;
    if (resetn) begin
      if (cpu_req && (!vid_req || w_force_cpu)) w_cpu_gnt = 1'b1;
      else if (vid_req)                         w_vid_gnt = 1'b1;
    end
  end

  // Register the one RAM access for this slot; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ram_ce   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ram_ce <= w_vid_gnt | w_cpu_gnt;
      r_ram_we <= w_cpu_gnt & cpu_we;
      if (w_cpu_gnt) begin
        r_ram_addr <= cpu_addr;
        r_ram_din  <= cpu_wdata;
      end else if (w_vid_gnt) begin
        r_ram_addr <= vid_addr;
        r_ram_din  <= cpu_wdata;
      end
    end
  end

  // Only reads carry a valid tag, so writes never produce an rvalid.
  vram_tag_pipe #(
    .RAM_LAT (RAM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .i_valid (w_vid_gnt | (w_cpu_gnt & ~cpu_we)),
    .i_owner (w_cpu_gnt),
    .o_valid (w_ret_valid),
    .o_owner (w_ret_owner)
  );

  // Capture returning RAM data for its owner; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vid_rvalid <= 1'b0;
      r_vid_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      r_vid_rvalid <= w_ret_valid && (w_ret_owner == OWN_VID);
      r_cpu_rvalid <= w_ret_valid && (w_ret_owner == OWN_CPU);
      if (w_ret_valid && (w_ret_owner == OWN_VID)) r_vid_rdata <= ram_dout;
      if (w_ret_valid && (w_ret_owner == OWN_CPU)) r_cpu_rdata <= ram_dout;
    end
  end

  assign vid_gnt    = w_vid_gnt;
  assign cpu_gnt    = w_cpu_gnt;
  assign ram_ce     = r_ram_ce;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign vid_rvalid = r_vid_rvalid;
  assign vid_rdata  = r_vid_rdata;
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = r_cpu_rdata;

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Directed bench for zx_vram_arbiter with a behavioural RAM, a shadow memory
// and a queue of expected read returns (owner, data, issue cycle).
module tb_zx_vram_arbiter;
  import zx_vram_pkg::*;

  parameter int RAM_LAT      = 1;
  parameter int CPU_MAX_WAIT = 4;
  localparam int RET_LAT     = RAM_LAT + 2;

  logic        clk;
  logic        resetn;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_gnt;
  logic        vid_rvalid;
  logic [7:0]  vid_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        ram_ce;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  zx_vram_arbiter #(
    .AW           (13),
    .DW           (8),
    .RAM_LAT      (RAM_LAT),
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_gnt    (vid_gnt),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      0:       return 8'hA5;
      1:       return 8'h11;
      2:       return 8'h22;
      3:       return 8'h33;
      default: return 8'(a) ^ 8'h3C;
    endcase
  endfunction

  // Behavioural synchronous RAM with RAM_LAT cycles of read latency.
  logic [7:0] ram_mem [8192];
  logic [7:0] rd_pipe [RAM_LAT];
  logic       ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 8192; i++) ram_mem[i] <= init_byte(i);
      ram_loaded <= 1'b1;
    end else if (ram_ce && ram_we) begin
      ram_mem[ram_addr] <= ram_din;
    end
    if (ram_ce && !ram_we) rd_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[RAM_LAT-1];

  // Scoreboard of expected read returns.
  typedef struct {
    logic       owner;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t       q[$];
  logic [7:0] exp_mem [8192];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One requester cycle: drive after the edge, check grants mid-cycle, and
  // record what a granted access should later return.
  task automatic do_cycle(input logic v_req, input logic [12:0] v_addr,
                          input logic c_req, input logic c_we,
                          input logic [12:0] c_addr, input logic [7:0] c_wdata,
                          input logic exp_vg, input logic exp_cg, input string tag);
    @(posedge clk); #1;
    vid_req   = v_req;
    vid_addr  = v_addr;
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    @(negedge clk);
    check({tag, ".vid_gnt"}, 32'(vid_gnt), 32'(exp_vg));
    check({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'(exp_cg));
    if (exp_vg) q.push_back('{owner: 1'b0, data: exp_mem[v_addr], cyc: cyc});
    if (exp_cg) begin
      if (c_we) exp_mem[c_addr] = c_wdata;
      else      q.push_back('{owner: 1'b1, data: exp_mem[c_addr], cyc: cyc});
    end
  endtask

  task automatic idle(input string tag);
    do_cycle(1'b0, 13'd0, 1'b0, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  // Return monitor: pops the scoreboard on every rvalid and checks hold.
  logic       prev_rstn = 1'b0;
  logic [7:0] last_vid  = 8'h00;
  logic [7:0] last_cpu  = 8'h00;
  always @(negedge clk) begin
    if (resetn) begin
      check("rv_exclusive", 32'(vid_rvalid & cpu_rvalid), 32'd0);
      if (vid_rvalid || cpu_rvalid) begin
        check("rv_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          check("rv_owner",   32'(cpu_rvalid), 32'(q[0].owner));
          check("rv_data",    32'(cpu_rvalid ? cpu_rdata : vid_rdata), 32'(q[0].data));
          check("rv_latency", 32'(cyc - q[0].cyc), 32'(RET_LAT));
          void'(q.pop_front());
        end
      end
      if (prev_rstn) begin
        if (!vid_rvalid) check("vid_rdata_hold", 32'(vid_rdata), 32'(last_vid));
        if (!cpu_rvalid) check("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_cpu));
      end
    end
    prev_rstn <= resetn;
    last_vid  <= vid_rdata;
    last_cpu  <= cpu_rdata;
  end

  int wait_m;

  initial begin
    for (int i = 0; i < 8192; i++) exp_mem[i] = init_byte(i);
    resetn    = 1'b0;
    vid_req   = 1'b0;
    vid_addr  = 13'd0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 13'd0;
    cpu_wdata = 8'h00;

    // Reset: grants gated off even with both requests high, outputs cleared.
    @(posedge clk); #1;
    vid_req = 1'b1;
    cpu_req = 1'b1;
    @(negedge clk);
    check("rst.vid_gnt",    32'(vid_gnt), 32'd0);
    check("rst.cpu_gnt",    32'(cpu_gnt), 32'd0);
    check("rst.ram_ce",     32'(ram_ce), 32'd0);
    check("rst.ram_we",     32'(ram_we), 32'd0);
    check("rst.ram_addr",   32'(ram_addr), 32'd0);
    check("rst.ram_din",    32'(ram_din), 32'd0);
    check("rst.vid_rvalid", 32'(vid_rvalid), 32'd0);
    check("rst.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst.vid_rdata",  32'(vid_rdata), 32'd0);
    check("rst.cpu_rdata",  32'(cpu_rdata), 32'd0);
    @(posedge clk); #1;
    resetn  = 1'b1;
    vid_req = 1'b0;
    cpu_req = 1'b0;

    // Single video read of address 0 (0xA5).
    do_cycle(1'b1, 13'd0, 1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, "vid_rd0");
    idle("vid_rd0.next");
    check("vid_rd0.ram_ce",   32'(ram_ce), 32'd1);
    check("vid_rd0.ram_we",   32'(ram_we), 32'd0);
    check("vid_rd0.ram_addr", 32'(ram_addr), 32'd0);
    repeat (4) idle("vid_rd0.drain");

    // CPU write then read of the first attribute byte.
    do_cycle(1'b0, 13'd0, 1'b1, 1'b1, 13'(VRAM_ATTR_BASE), 8'h47, 1'b0, 1'b1, "cpu_wr");
    do_cycle(1'b0, 13'd0, 1'b1, 1'b0, 13'(VRAM_ATTR_BASE), 8'h00, 1'b0, 1'b1, "cpu_rd");
    check("cpu_wr.ram_we",   32'(ram_we), 32'd1);
    check("cpu_wr.ram_addr", 32'(ram_addr), 32'(VRAM_ATTR_BASE));
    check("cpu_wr.ram_din",  32'(ram_din), 32'h47);
    idle("cpu_rd.next");
    check("cpu_rd.ram_ce",   32'(ram_ce), 32'd1);
    check("cpu_rd.ram_we",   32'(ram_we), 32'd0);
    check("cpu_rd.ram_addr", 32'(ram_addr), 32'(VRAM_ATTR_BASE));
    repeat (4) idle("cpu_rd.drain");

    // CPU write followed immediately by a video read of the same byte.
    do_cycle(1'b0, 13'd0, 1'b1, 1'b1, 13'd100, 8'h5C, 1'b0, 1'b1, "raw_wr");
    do_cycle(1'b1, 13'd100, 1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, "raw_rd");
    repeat (4) idle("raw.drain");

    // Back-to-back vid/cpu/vid reads of addresses 1, 2, 3.
    do_cycle(1'b1, 13'd1, 1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, "b2b_v1");
    do_cycle(1'b0, 13'd0, 1'b1, 1'b0, 13'd2, 8'h00, 1'b0, 1'b1, "b2b_c2");
    do_cycle(1'b1, 13'd3, 1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, "b2b_v3");
    repeat (5) idle("b2b.drain");

    // Contention for 10 cycles; the guard (if built in) forces a CPU slot.
    wait_m = 0;
    for (int k = 1; k <= 10; k++) begin
      logic ec;
`ifdef ZX_VRAM_STARVE_GUARD_EN
      ec = (wait_m == CPU_MAX_WAIT);
`else
      ec = 1'b0;
`endif
      do_cycle(1'b1, 13'd40, 1'b1, 1'b0, 13'd41, 8'h00, !ec, ec, $sformatf("contend%0d", k));
      wait_m = ec ? 0 : ((wait_m < CPU_MAX_WAIT) ? wait_m + 1 : wait_m);
    end
    repeat (6) idle("contend.drain");

    // Reset for one cycle right after a video grant: the read must vanish.
    do_cycle(1'b1, 13'd7, 1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, "mid_rst");
    @(posedge clk); #1;
    resetn  = 1'b0;
    vid_req = 1'b1;
    cpu_req = 1'b1;
    q.delete();
    @(negedge clk);
    check("mid_rst.vid_gnt", 32'(vid_gnt), 32'd0);
    check("mid_rst.cpu_gnt", 32'(cpu_gnt), 32'd0);
    @(posedge clk); #1;
    resetn  = 1'b1;
    vid_req = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("mid_rst.ram_ce",     32'(ram_ce), 32'd0);
    check("mid_rst.ram_addr",   32'(ram_addr), 32'd0);
    check("mid_rst.vid_rvalid", 32'(vid_rvalid), 32'd0);
    check("mid_rst.vid_rdata",  32'(vid_rdata), 32'd0);
    check("mid_rst.cpu_rdata",  32'(cpu_rdata), 32'd0);
    repeat (6) idle("mid_rst.quiet");

    // First grant after reset behaves normally.
    do_cycle(1'b1, 13'd0, 1'b0, 1'b0, 13'd0, 8'h00, 1'b1, 1'b0, "post_rst");
    idle("post_rst.next");
    check("post_rst.ram_ce", 32'(ram_ce), 32'd1);
    repeat (8) idle("final.drain");

    check("sb_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zx_vram_arbiter.md
Name: zx_vram_arbiter

Overview:
Shares the single-port ZX Spectrum video RAM (6912 bytes: bitmap at 0..6143, attributes at 6144..6911) between two requesters:
- the video fetch pipeline (pixel/attribute reads, time-critical);
- the CPU bus (reads and writes).

It issues at most one RAM access per clock, routes returned read data back to the owner through a latency-matched tag pipe, and reports grants so each requester can stall.

Parameters:
- AW, 13, address width
- DW, 8, data width
- RAM_LAT, 1, RAM read latency in cycles (ram_ce high to ram_dout valid), range 1..4
- CPU_MAX_WAIT, 4, consecutive denied CPU cycles before the starvation guard forces a CPU slot (used only with the optional feature)

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- vid_req  in  1  video read request, level, held until granted
- vid_addr  in  AW  video read address
- vid_gnt  out  1  video request accepted this cycle (combinational)
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  DW  video read data
- cpu_req  in  1  CPU access request, level, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- ram_ce  out  1  RAM access enable (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  AW  RAM address (registered)
- ram_din  out  DW  RAM write data (registered)
- ram_dout  in  DW  RAM read data

Behaviour:
- Reset is synchronous and active-low (resetn), on clock clk.
- During reset:
  - all registered outputs are 0;
  - the tag pipe is cleared;
  - the wait counter is 0.
- Reads in flight at reset are discarded: no rvalid for them after reset is released.
- The gnt outputs are 0 whenever resetn is low.
- Arbitration in cycle t, combinational on the req inputs:
  - vid_req only: vid_gnt = 1.
  - cpu_req only: cpu_gnt = 1.
  - Both requesting: video wins (cpu_gnt = 0), except when the starvation guard fires (see Optional Feature).
  - Never both gnt high in one cycle.
- Requester contract:
  - address, we and wdata must be stable while req is high.
  - A requester sees its gnt in the same cycle and may change or drop req on the next cycle.
- Issue, at the edge ending cycle t for the granted requester:
  - ram_ce = 1, ram_addr = granted address;
  - ram_we = cpu_we & cpu_gnt; ram_din = cpu_wdata.
  - With no grant: ram_ce = 0, ram_we = 0; ram_addr and ram_din hold their previous values.
- Tag pipe:
  - RAM_LAT+1 stages of {valid, owner}.
  - Stage 0 is loaded at issue: valid = 1 only for reads; owner is VID or CPU.
  - Advances every cycle.
- Return:
  - ram_dout is sampled RAM_LAT cycles after ram_ce.
  - The owner's rvalid and rdata are registered, so rvalid is high in cycle t+2+RAM_LAT (t+3 at default), for exactly one cycle.
  - The other owner's rvalid stays 0; rdata holds its value when rvalid is 0.
- Throughput:
  - Fully pipelined: back-to-back grants every cycle.
  - Read data returns in issue order.
  - A CPU write followed by a video read of the same address returns the new data.
- Writes produce no rvalid. Completion is signalled by cpu_gnt alone.
- When cpu_req is low, the CPU has no cost: video gets every slot.

Optional Feature:
Macro: ZX_VRAM_STARVE_GUARD_EN.
- Defined:
  - A counter (width clog2(CPU_MAX_WAIT+1)) increments each cycle cpu_req = 1 and cpu_gnt = 0, saturating at CPU_MAX_WAIT.
  - It clears on cpu_gnt or when cpu_req = 0.
  - When the counter equals CPU_MAX_WAIT, the CPU wins the next contended cycle and video is denied (vid_gnt = 0) for that one cycle.
- Not defined:
  - Strict video priority; the CPU may wait indefinitely.
  - No counter logic is synthesized.

Decomposition:
- Package zx_vram_pkg:
  - VRAM_AW = 13, VRAM_DW = 8;
  - VRAM_ATTR_BASE = 6144, VRAM_SIZE = 6912;
  - owner enum OWN_VID = 0, OWN_CPU = 1;
  - tag struct {valid, owner}.
- Sub-module vram_tag_pipe: parameterised by RAM_LAT; shift register of tags with synchronous clear.

Test Plan:
- vid_req alone, addr 0x0000, RAM preloaded 0xA5:
  - vid_gnt high the same cycle;
  - ram_ce high next cycle;
  - vid_rvalid = 1 with vid_rdata = 0xA5 exactly 3 cycles after the grant (RAM_LAT = 1);
  - cpu_rvalid stays 0.
- CPU write addr 6144 data 0x47, then CPU read addr 6144:
  - ram_we = 1 only on the first issue;
  - cpu_rvalid returns 0x47;
  - no rvalid for the write.
- vid_req and cpu_req both held high for 10 cycles:
  - guard off: vid_gnt high all 10 cycles, cpu_gnt 0;
  - guard on (CPU_MAX_WAIT = 4): cpu_gnt high in cycle 5, vid_gnt 0 in that cycle only.
- Alternating back-to-back grants vid/cpu/vid over addresses 1, 2, 3 (RAM contents 0x11, 0x22, 0x33):
  - rvalids arrive in issue order on consecutive cycles;
  - each carries the correct data and owner.
- resetn asserted low one cycle after a video read grant:
  - all outputs 0;
  - no vid_rvalid appears after reset is released;
  - the first post-reset grant works normally.
- RAM_LAT = 3 build, single CPU read:
  - cpu_rvalid exactly 5 cycles after cpu_gnt.
